// File: rtl/alu_issue_arbiter_if.sv
// alu_issue_arbiter_if: request, ALU-side and response signals of alu_issue_arbiter.
interface alu_issue_arbiter_if;
  logic        req0_valid, req0_ready;
  logic [6:0]  req0_opcode, req0_funct7;
  logic [2:0]  req0_funct3;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [6:0]  req1_opcode, req1_funct7;
  logic [2:0]  req1_funct3;
  logic [31:0] req1_a, req1_b;
  logic [6:0]  alu_opcode, alu_funct7;
  logic [2:0]  alu_funct3;
  logic [31:0] alu_a, alu_b, alu_c;
  logic        rsp_valid, rsp_id;
  logic [31:0] rsp_data;
  logic        busy;
  modport slave (
    input  req0_valid, req0_opcode, req0_funct7, req0_funct3, req0_a, req0_b,
    input  req1_valid, req1_opcode, req1_funct7, req1_funct3, req1_a, req1_b,
    input  alu_c,
    output req0_ready, req1_ready,
    output alu_opcode, alu_funct7, alu_funct3, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_data, busy
  );
  modport master (
    output req0_valid, req0_opcode, req0_funct7, req0_funct3, req0_a, req0_b,
    output req1_valid, req1_opcode, req1_funct7, req1_funct3, req1_a, req1_b,
    output alu_c,
    input  req0_ready, req1_ready,
    input  alu_opcode, alu_funct7, alu_funct3, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: two-requester ALU issue arbiter and tagged result router; define ALU_ARB_RR_EN for round-robin, else requester 0 has fixed priority.
module alu_issue_arbiter #(
  parameter int ALU_LATENCY = 2
) (
  input logic                clk,
  input logic                rst,
  alu_issue_arbiter_if.slave bus
);
  // One stage beyond the ALU latency so the tag leaves the pipe on the edge alu_c is stable.
  localparam int D = ALU_LATENCY + 1;
  logic         grant, gid;
  logic [D-1:0] sv, sid;
`ifdef ALU_ARB_RR_EN
  logic prio;
  assign gid = bus.req1_valid && (!bus.req0_valid || prio);
  always_ff @(posedge clk)
    prio <= rst ? 1'b0 : grant ? ~gid : prio;
`else
  assign gid = bus.req1_valid && !bus.req0_valid;
`endif
  assign grant          = !rst && (bus.req0_valid || bus.req1_valid);
  assign bus.req0_ready = grant && !gid;
  assign bus.req1_ready = grant && gid;
  always_ff @(posedge clk)
    if (rst) begin
      bus.alu_opcode <= '0;
      bus.alu_funct7 <= '0;
      bus.alu_funct3 <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
    end else if (grant) begin
      bus.alu_opcode <= gid ? bus.req1_opcode : bus.req0_opcode;
      bus.alu_funct7 <= gid ? bus.req1_funct7 : bus.req0_funct7;
      bus.alu_funct3 <= gid ? bus.req1_funct3 : bus.req0_funct3;
      bus.alu_a      <= gid ? bus.req1_a : bus.req0_a;
      bus.alu_b      <= gid ? bus.req1_b : bus.req0_b;
    end
  always_ff @(posedge clk) begin
    sv  <= rst ? '0 : {sv[D-2:0], grant};
    sid <= {sid[D-2:0], gid};
  end
  always_ff @(posedge clk)
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_data  <= '0;
    end else begin
      bus.rsp_valid <= sv[D-1];
      bus.rsp_id    <= sv[D-1] ? sid[D-1] : bus.rsp_id;
      bus.rsp_data  <= sv[D-1] ? bus.alu_c : bus.rsp_data;
    end
  assign bus.busy = |sv || bus.rsp_valid;
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: queue-based reference model with per-cycle compare plus directed literal checks.
module tb_alu_issue_arbiter;
  localparam int L = 2;
  logic clk = 0, rst = 1;
  int   checks = 0, errors = 0, cyc = 0;
  bit   check_en = 0;
  always #5 clk = ~clk;
  alu_issue_arbiter_if bus();
  alu_issue_arbiter #(.ALU_LATENCY(L)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [31:0] alu_fn(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a, b);
    return f3 == 3'd0 ? (f7[5] ? a - b : a + b) : f3 == 3'd6 ? (a | b) : f3 == 3'd7 ? (a & b) : (a ^ b);
  endfunction

  // Environment ALU: fixed latency L from the registered inputs.
  logic [31:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= alu_fn(bus.alu_funct7, bus.alu_funct3, bus.alu_a, bus.alu_b);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.alu_c = pipe[L-1];

  task automatic chk(input string nm, input logic [80:0] act, input logic [80:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: every accepted op becomes a response due L+1 edges later.
  typedef struct { int due; bit id; logic [31:0] d; } ent_t;
  ent_t q[$];
  bit   m_prio, m_rv, m_rid, mg, mid;
  logic [31:0] m_rd;
  logic [80:0] m_alu;
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      m_prio = 0; m_rv = 0; m_rid = 0; m_rd = '0; m_alu = '0;
    end else begin
      mg  = bus.req0_valid || bus.req1_valid;
      mid = bus.req1_valid && (!bus.req0_valid || m_prio);
      if (mg) begin
        m_alu = mid ? {bus.req1_opcode, bus.req1_funct7, bus.req1_funct3, bus.req1_a, bus.req1_b}
                    : {bus.req0_opcode, bus.req0_funct7, bus.req0_funct3, bus.req0_a, bus.req0_b};
        q.push_back('{cyc + L + 1, mid, alu_fn(m_alu[73:67], m_alu[66:64], m_alu[63:32], m_alu[31:0])});
`ifdef ALU_ARB_RR_EN
        m_prio = !mid;
`endif
      end
      m_rv = q.size() != 0 && q[0].due == cyc;
      if (m_rv) begin
        m_rid = q[0].id;
        m_rd  = q[0].d;
        void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) if (check_en) begin
    chk("req0_ready", 81'(bus.req0_ready), 81'(!rst && bus.req0_valid && !(bus.req1_valid && m_prio)));
    chk("req1_ready", 81'(bus.req1_ready), 81'(!rst && bus.req1_valid && (!bus.req0_valid || m_prio)));
    chk("alu_in", {bus.alu_opcode, bus.alu_funct7, bus.alu_funct3, bus.alu_a, bus.alu_b}, m_alu);
    chk("rsp_valid", 81'(bus.rsp_valid), 81'(m_rv));
    chk("rsp_id", 81'(bus.rsp_id), 81'(m_rid));
    chk("rsp_data", 81'(bus.rsp_data), 81'(m_rd));
    chk("busy", 81'(bus.busy), 81'(q.size() != 0 || m_rv));
  end

  typedef struct { bit id; logic [31:0] d; int c; } rsp_t;
  rsp_t rs[$];
  always @(negedge clk) if (bus.rsp_valid) rs.push_back('{bus.rsp_id, bus.rsp_data, cyc});

  task automatic issue(input bit id, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, output int acc);
    bit done = 0;
    acc = -1;
    if (id) begin
      bus.req1_valid = 1; bus.req1_opcode = 7'b0110011; bus.req1_funct7 = f7; bus.req1_funct3 = f3; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1; bus.req0_opcode = 7'b0110011; bus.req0_funct7 = f7; bus.req0_funct3 = f3; bus.req0_a = a; bus.req0_b = b;
    end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = id ? bus.req1_ready : bus.req0_ready;
      if (done) acc = cyc + 1;
      @(posedge clk); #1;
    end
    if (id) bus.req1_valid = 0; else bus.req0_valid = 0;
    chk("issue_accepted", 81'(done), 81'(1));
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  int acc, n0;
  int g[4];
  initial begin
    bus.req0_valid = 0; bus.req0_opcode = '0; bus.req0_funct7 = '0; bus.req0_funct3 = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 0; bus.req1_opcode = '0; bus.req1_funct7 = '0; bus.req1_funct3 = '0; bus.req1_a = '0; bus.req1_b = '0;
    @(posedge clk);
    check_en = 1;
    do_reset();
    chk("reset_rsp_valid", 81'(bus.rsp_valid), 81'(0));
    chk("reset_busy", 81'(bus.busy), 81'(0));
    chk("reset_alu_a", 81'(bus.alu_a), 81'(0));
    chk("reset_rsp", {bus.rsp_id, bus.rsp_data}, 81'(0));
    // Single ADD from requester 0
    n0 = rs.size();
    issue(0, 7'd0, 3'd0, 32'd45, 32'd45, acc);
    repeat (L + 4) @(posedge clk);
    #1;
    chk("add_count", 81'(rs.size() - n0), 81'(1));
    if (rs.size() > n0) begin
      chk("add_data", 81'(rs[n0].d), 81'(90));
      chk("add_id", 81'(rs[n0].id), 81'(0));
      chk("add_latency", 81'(rs[n0].c - acc), 81'(L + 1));
    end
    // Both requesters continuously valid
    do_reset();
    n0 = rs.size();
    bus.req0_valid = 1; bus.req0_opcode = 7'b0110011; bus.req0_funct7 = 7'b0100000; bus.req0_funct3 = 3'd0; bus.req0_a = 45; bus.req0_b = 45;
    bus.req1_valid = 1; bus.req1_opcode = 7'b0110011; bus.req1_funct7 = 7'd0; bus.req1_funct3 = 3'd7; bus.req1_a = 45; bus.req1_b = 45;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      g[i] = bus.req1_ready ? 1 : bus.req0_ready ? 0 : 2;
      @(posedge clk); #1;
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    repeat (L + 4) @(posedge clk);
    #1;
    chk("tie_count", 81'(rs.size() - n0), 81'(4));
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
      chk("tie_grant", 81'(g[i]), 81'(i % 2));
      if (rs.size() > n0 + i) chk("tie_rsp", {rs[n0+i].id, rs[n0+i].d}, {1'(i % 2), (i % 2) ? 32'd45 : 32'd0});
`else
      chk("tie_grant", 81'(g[i]), 81'(0));
      if (rs.size() > n0 + i) chk("tie_rsp", {rs[n0+i].id, rs[n0+i].d}, {1'b0, 32'd0});
`endif
    end
    // Back-to-back requester 1 stream
    n0 = rs.size();
    issue(1, 7'd0, 3'd6, 32'd45, 32'd45, acc);
    issue(1, 7'd0, 3'd0, 32'd45, 32'd45, acc);
    issue(1, 7'b0100000, 3'd0, 32'd45, 32'd45, acc);
    repeat (L + 4) @(posedge clk);
    #1;
    chk("stream_count", 81'(rs.size() - n0), 81'(3));
    if (rs.size() >= n0 + 3) begin
      chk("stream_data0", {rs[n0].id, rs[n0].d}, {1'b1, 32'd45});
      chk("stream_data1", {rs[n0+1].id, rs[n0+1].d}, {1'b1, 32'd90});
      chk("stream_data2", {rs[n0+2].id, rs[n0+2].d}, {1'b1, 32'd0});
      chk("stream_contig", 81'(rs[n0+2].c - rs[n0].c), 81'(2));
    end
    // Reset with two ops in flight
    n0 = rs.size();
    issue(0, 7'd0, 3'd0, 32'd1, 32'd2, acc);
    issue(1, 7'd0, 3'd0, 32'd3, 32'd4, acc);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_busy", 81'(bus.busy), 81'(0));
    chk("rst_outs", {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.alu_a, bus.alu_b}, 81'(0));
    repeat (8) @(posedge clk);
    #1;
    chk("rst_no_rsp", 81'(rs.size() - n0), 81'(0));
    // Single op followed by an idle gap
    n0 = rs.size();
    issue(0, 7'd0, 3'd0, 32'd7, 32'd3, acc);
    repeat (10) @(posedge clk);
    #1;
    chk("idle_count", 81'(rs.size() - n0), 81'(1));
    if (rs.size() > n0) chk("idle_data", 81'(rs[n0].d), 81'(10));
    chk("idle_alu_hold", {bus.alu_a, bus.alu_b}, {32'd7, 32'd3});
    chk("idle_busy", 81'(bus.busy), 81'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
